// File: rtl/tristate_bus_responder_if.sv
// Request/acknowledge side of the half-duplex responder bus.
// The shared data lines stay a plain inout on the responder itself.
interface tristate_bus_responder_if #(
  parameter int AW = 4
) ();
  logic          bus_req;
  logic          bus_rw;
  logic [AW-1:0] bus_addr;
  logic          bus_ack;
  logic          bus_err;

  modport master (
    output bus_req,
    output bus_rw,
    output bus_addr,
    input  bus_ack,
    input  bus_err
  );

  modport slave (
    input  bus_req,
    input  bus_rw,
    input  bus_addr,
    output bus_ack,
    output bus_err
  );
endinterface

// File: rtl/tristate_bus_responder.sv
// Responder for the half-duplex req/ack bus: DEPTH-word register bank plus a local access port.
// Define RESP_TURNAROUND_EN to insert a guaranteed high-Z TURN cycle before read data is driven.
module tristate_bus_responder #(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int DEPTH = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  tristate_bus_responder_if.slave        bus,
  inout  wire  [DW-1:0]                  bus_data,
  input  logic                           loc_we,
  input  logic [AW-1:0]                  loc_addr,
  input  logic [DW-1:0]                  loc_wdata,
  output logic [DW-1:0]                  loc_rdata
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TURN  = 2'd1,
    S_DRIVE = 2'd2,
    S_WACK  = 2'd3
  } state_t;

  function automatic logic in_range(input logic [AW-1:0] addr);
    return ({1'b0, addr} < DEPTH_W);
  endfunction

  state_t        r_state;
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;
  logic          r_oe;
  logic          r_ack;
  logic          r_err;
`ifdef RESP_TURNAROUND_EN
  logic          r_oor;
`endif

  logic          w_bus_in_range;
  logic          w_bus_wr;
  logic          w_loc_wr;
  logic [DW-1:0] w_rd_word;

  assign w_bus_in_range = in_range(bus.bus_addr);
  assign w_bus_wr       = (r_state == S_IDLE) && bus.bus_req && !bus.bus_rw && w_bus_in_range;
  assign w_loc_wr       = loc_we && in_range(loc_addr);
  assign w_rd_word      = w_bus_in_range ? r_mem[bus.bus_addr] : {DW{1'b1}};

  assign bus_data    = r_oe ? r_rdata : {DW{1'bz}};
  assign bus.bus_ack = r_ack;
  assign bus.bus_err = r_err;

  // Register bank; the bus write is issued last so it wins a same-word collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DW{1'b0}};
      end
    end else begin
      if (w_loc_wr) begin
        r_mem[loc_addr] <= loc_wdata;
      end
      if (w_bus_wr) begin
        r_mem[bus.bus_addr] <= bus_data;
      end
    end
  end

  // Local read port, all-ones outside the implemented range.
  always_comb begin
    loc_rdata = {DW{1'b1}};
    if (in_range(loc_addr)) begin
      loc_rdata = r_mem[loc_addr];
    end else begin
      loc_rdata = {DW{1'b1}};
    end
  end

  // Handshake FSM; read data is captured at acceptance so later local writes cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rdata <= {DW{1'b0}};
      r_oe    <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
`ifdef RESP_TURNAROUND_EN
      r_oor   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.bus_req) begin
            if (bus.bus_rw) begin
              r_rdata <= w_rd_word;
`ifdef RESP_TURNAROUND_EN
              r_oor   <= !w_bus_in_range;
              r_state <= S_TURN;
`else
              r_oe    <= 1'b1;
              r_ack   <= 1'b1;
              r_err   <= !w_bus_in_range;
              r_state <= S_DRIVE;
`endif
            end else begin
              r_ack   <= 1'b1;
              r_err   <= !w_bus_in_range;
              r_state <= S_WACK;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_TURN: begin
`ifdef RESP_TURNAROUND_EN
          if (bus.bus_req) begin
            r_oe    <= 1'b1;
            r_ack   <= 1'b1;
            r_err   <= r_oor;
            r_state <= S_DRIVE;
          end else begin
            r_state <= S_IDLE;
          end
`else
          r_state <= S_IDLE;
`endif
        end
        S_DRIVE, S_WACK: begin
          if (!bus.bus_req) begin
            r_oe    <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= r_state;
          end
        end
        default: begin
          r_oe    <= 1'b0;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
